// File: rtl/pru_ingress_arb_if.sv
// Link bundle between the 17 port-interface stages, the ingress arbiter and
// the routing core. The arbiter connects through the master modport; the
// port interfaces and routing core (or a bench) use the slave modport.
interface pru_ingress_arb_if #(
  parameter int PW = 128,
  parameter int NP = 17,
  parameter int SW = 5
);

  // Requester side: one vld/ack pair and one beat slice per port.
  logic [NP-1:0]    iReq_vld;
  logic [NP*PW-1:0] iReq_pkt;
  logic [NP-1:0]    oReq_ack;

  // Routing-core side: single registered beat stream.
  logic             oArb_vld;
  logic [PW-1:0]    oArb_pkt;
  logic [SW-1:0]    oArb_src;
  logic             oArb_sop;
  logic             oArb_eop;
  logic             iArb_ack;

  // Arbiter view.
  modport master (
    input  iReq_vld,
    input  iReq_pkt,
    output oReq_ack,
    output oArb_vld,
    output oArb_pkt,
    output oArb_src,
    output oArb_sop,
    output oArb_eop,
    input  iArb_ack
  );

  // Port-interface / routing-core view.
  modport slave (
    output iReq_vld,
    output iReq_pkt,
    input  oReq_ack,
    input  oArb_vld,
    input  oArb_pkt,
    input  oArb_src,
    input  oArb_sop,
    input  oArb_eop,
    output iArb_ack
  );

endinterface

// File: rtl/pru_ingress_arb.sv
// Ingress arbiter: round-robin selection among NP vld/ack packet streams,
// grant held for a whole packet (length taken from the head beat SIZE
// field), forwarded through one registered output stage tagged with the
// source index and sop/eop markers.
module pru_ingress_arb #(
  parameter int PW = 128,
  parameter int NP = 17,
  parameter int SW = 5
) (
  input  logic              iClk,
  input  logic              iRst,
  pru_ingress_arb_if.master bus
);

  // Head-beat SIZE field: number of payload beats following the head.
  localparam int SIZE_MSB = 121;
  localparam int SIZE_LSB = 114;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  // Control state.
  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_rr_ptr;
  logic [SW-1:0]   w_rr_ptr_nxt;
  logic [SW-1:0]   r_lock;
  logic [SW-1:0]   w_lock_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;

  // Output stage.
  logic            r_arb_vld;
  logic [PW-1:0]   r_arb_pkt;
  logic [SW-1:0]   r_arb_src;
  logic            r_arb_sop;
  logic            r_arb_eop;

  // Datapath / decision wires.
  logic [PW-1:0]   w_pkt [NP];
  logic            w_slot_free;
  logic [SW:0]     w_find;
  logic            w_any;
  logic [SW-1:0]   w_win;
  logic [SW-1:0]   w_sel;
  logic [PW-1:0]   w_sel_pkt;
  logic [7:0]      w_sel_size;
  logic [NP-1:0]   w_ack;
  logic            w_load;
  logic            w_load_sop;
  logic            w_load_eop;

  // Round-robin search: first requester strictly after ptr, wrapping at NP.
  // Returns {found, index}.
  function automatic logic [SW:0] find_winner(input logic [NP-1:0] vld,
                                               input logic [SW-1:0] ptr);
    logic [SW:0]   res;
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    res = '0;
    for (int k = 1; k <= NP; k++) begin
      sum = {1'b0, ptr} + (SW+1)'(k);
      if (sum >= (SW+1)'(NP)) sum = sum - (SW+1)'(NP);
      idx = sum[SW-1:0];
      if (!res[SW] && vld[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Split the flat beat bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < NP; i++) w_pkt[i] = bus.iReq_pkt[i*PW +: PW];
  end

  // Slot availability, winner search and selected-beat mux.
  assign w_slot_free = !r_arb_vld || bus.iArb_ack;
  assign w_find      = find_winner(bus.iReq_vld, r_rr_ptr);
  assign w_any       = w_find[SW];
  assign w_win       = w_find[SW-1:0];
  assign w_sel       = (r_state == ST_IDLE) ? w_win : r_lock;
  assign w_sel_pkt   = w_pkt[w_sel];
  assign w_sel_size  = w_sel_pkt[SIZE_MSB:SIZE_LSB];

  // FSM next-state, grant and output-stage load decision.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_lock_nxt   = r_lock;
    w_cnt_nxt    = r_cnt;
    w_ack        = '0;
    w_load       = 1'b0;
    w_load_sop   = 1'b0;
    w_load_eop   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any && w_slot_free) begin
          w_ack[w_win] = 1'b1;
          w_load       = 1'b1;
          w_load_sop   = 1'b1;
          w_cnt_nxt    = w_sel_size;
          if (w_sel_size == 8'd0) begin
            // Single-beat packet: done in one transfer, stay open for a new head.
            w_load_eop   = 1'b1;
            w_rr_ptr_nxt = w_win;
          end else begin
            w_state_nxt = ST_BUSY;
            w_lock_nxt  = w_win;
          end
        end
      end

      ST_BUSY: begin
        // Only the locked requester may move; a dropped vld simply stalls.
        if (bus.iReq_vld[r_lock] && w_slot_free) begin
          w_ack[r_lock] = 1'b1;
          w_load        = 1'b1;
          w_cnt_nxt     = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_load_eop   = 1'b1;
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = r_lock;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Acks are combinational, but must read zero while reset is held.
  assign bus.oReq_ack = iRst ? '0 : w_ack;

  // Arbitration state registers.
  always_ff @(posedge iClk or posedge iRst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (iRst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= SW'(NP-1);
      r_lock   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_lock   <= w_lock_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Output stage: load on any input transfer, otherwise empty on downstream ack.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_arb_vld <= 1'b0;
      r_arb_pkt <= '0;
      r_arb_src <= '0;
      r_arb_sop <= 1'b0;
      r_arb_eop <= 1'b0;
    end else if (w_load) begin
      r_arb_vld <= 1'b1;
      r_arb_pkt <= w_sel_pkt;
      r_arb_src <= w_sel;
      r_arb_sop <= w_load_sop;
      r_arb_eop <= w_load_eop;
    end else if (bus.iArb_ack) begin
      r_arb_vld <= 1'b0;
    end
  end

  assign bus.oArb_vld = r_arb_vld;
  assign bus.oArb_pkt = r_arb_pkt;
  assign bus.oArb_src = r_arb_src;
  assign bus.oArb_sop = r_arb_sop;
  assign bus.oArb_eop = r_arb_eop;

`ifndef SYNTHESIS
  // At most one requester is ever granted in a cycle.
  a_ack_onehot: assert property (@(posedge iClk) disable iff (iRst)
    $onehot0(bus.oReq_ack));

  // BUSY always has at least one payload beat left to move.
  a_busy_cnt: assert property (@(posedge iClk) disable iff (iRst)
    (r_state == ST_BUSY) |-> (r_cnt != 8'd0));
`endif

endmodule
